// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine with a small prefetch queue.
//
// Requests sequential instruction words from instruction memory starting at
// RESET_PC. Each returned word is written to a circular queue together with
// its word address. The decode stage drains the queue through a valid/ready
// handshake. A redirect flushes the queue and restarts fetching at a new
// address.
//
// Optional feature macro: FETCH_QUEUE_PERF_EN adds the performance counters
// fetch_count and flush_count.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   imem_req       out  instruction memory request (RUN state only)
//   imem_addr      out  word address being fetched (the fetch PC)
//   imem_ack       in   completes the request in a cycle with imem_req high
//   imem_rdata     in   instruction word, valid while imem_ack is high
//   redirect_valid in   flush the queue and restart fetching at redirect_pc
//   redirect_pc    in   new fetch word address
//   out_valid      out  queue head is valid
//   out_ready      in   decode accepts the head
//   out_instr      out  head instruction word
//   out_pc         out  head word address
//   fetch_count    out  accepted pushes (FETCH_QUEUE_PERF_EN only)
//   flush_count    out  entries discarded by redirects (FETCH_QUEUE_PERF_EN only)
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, count_n;
  logic [PW-1:0] head, tail;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          push, pop;

  // Requests are suppressed in the redirect cycle; the new address is
  // presented from the following cycle.
  always_comb imem_req = (state == RUN) && !redirect_valid;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = mem_instr[head];
  assign out_pc    = mem_pc[head];

  always_comb begin
    push    = imem_req && imem_ack;
    pop     = out_valid && out_ready;
    count_n = count;
    if (redirect_valid)
      count_n = '0;
    else if (push && !pop)
      count_n = count + CNT_ONE;
    else if (pop && !push)
      count_n = count - CNT_ONE;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = RUN;
      RUN:  if (count_n == CNT_FULL) state_n = FULL;
      FULL: if (count_n < CNT_FULL)  state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (redirect_valid && state != IDLE)
      state_n = RUN;
    else if (redirect_valid)
      state_n = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else begin
      count <= count_n;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (push) begin
          mem_instr[tail] <= imem_rdata;
          mem_pc[tail]    <= fetch_pc;
          tail            <= tail + PTR_ONE;
          fetch_pc        <= fetch_pc + 32'd1;
        end
        if (pop)
          head <= head + PTR_ONE;
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else if (redirect_valid) begin
      // Every entry held at the redirect is discarded, including one that
      // decode was accepting in the same cycle.
      flush_count <= flush_count + 32'(count);
    end else if (push) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue. A
// queue-based reference model tracks fetched words, the fetch address and
// whether the post-reset idle cycle has elapsed. A second instance with
// RESET_PC = 32'hFFFFFFFF checks address wrap-around.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetch_count, flush_count, w_fetch_count, w_flush_count;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_QUEUE_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1),
    .out_instr(w_instr), .out_pc(w_pc)
`ifdef FETCH_QUEUE_PERF_EN
    , .fetch_count(w_fetch_count), .flush_count(w_flush_count)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [31:0] m_pc;
  bit          started;
  logic [31:0] m_fetch, m_flush;

  logic [31:0] w_exp[3];
  int unsigned w_seen = 0;

  function automatic bit m_req();
    return !reset && started && (q_pc.size() < DEPTH) && !redirect_valid;
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_instr.delete();
    m_pc    = 32'h0;
    started = 1'b0;
    m_fetch = '0;
    m_flush = '0;
  endtask

  task automatic model_step();
    bit req_now, do_pop, do_push;
    if (redirect_valid) begin
      m_flush = m_flush + 32'(q_pc.size());
      q_pc.delete();
      q_instr.delete();
      m_pc = redirect_pc;
    end else begin
      req_now = m_req();
      do_pop  = (q_pc.size() > 0) && out_ready;
      do_push = req_now && imem_ack;
      if (do_pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (do_push) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(imem_rdata);
        m_pc    = m_pc + 32'd1;
        m_fetch = m_fetch + 32'd1;
      end
    end
    started = 1'b1;
  endtask

  // One clock: drive at the falling edge, check 1 ns later, advance the
  // model at the rising edge.
  task automatic cycle(input bit rst, input bit ack, input bit rdy, input bit rv,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    @(negedge clk);
    reset          = rst;
    imem_ack       = ack;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = rdata;
    if (rst) model_reset();
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, q_pc.size() != 0});
    if (q_pc.size() != 0) begin
      check("out_pc", out_pc, q_pc[0]);
      check("out_instr", out_instr, q_instr[0]);
    end
    if (rst) begin
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
    end
`ifdef FETCH_QUEUE_PERF_EN
    check("fetch_count", fetch_count, m_fetch);
    check("flush_count", flush_count, m_flush);
`endif
    if (!rst && w_valid && w_seen < 3) begin
      check("wrap_out_pc", w_pc, w_exp[w_seen]);
      w_seen++;
    end
    @(posedge clk);
    if (!rst) model_step();
  endtask

  initial begin
    w_exp[0] = 32'hFFFF_FFFF;
    w_exp[1] = 32'h0000_0000;
    w_exp[2] = 32'h0000_0001;
    model_reset();

    repeat (3) cycle(1, 1, 0, 0, '0, $urandom);
    // Streaming with ack and ready tied high
    repeat (10) cycle(0, 1, 1, 0, '0, $urandom);
    // Fill to full, one pop, then hold
    repeat (8) cycle(0, 1, 0, 0, '0, $urandom);
    cycle(0, 1, 1, 0, '0, $urandom);
    repeat (4) cycle(0, 1, 0, 0, '0, $urandom);
    // Redirect with a full queue, then resume
    cycle(0, 1, 1, 1, 32'h40, $urandom);
    repeat (4) cycle(0, 1, 1, 0, '0, $urandom);
    // Delayed acknowledge
    repeat (3) cycle(0, 0, 1, 0, '0, $urandom);
    repeat (3) cycle(0, 1, 1, 0, '0, $urandom);
    // Reset while full with ack high
    repeat (8) cycle(0, 1, 0, 0, '0, $urandom);
    repeat (2) cycle(1, 1, 1, 0, '0, $urandom);
    // Redirect near the top of the address space
    repeat (2) cycle(0, 1, 1, 0, '0, $urandom);
    cycle(0, 1, 1, 1, 32'hFFFF_FFFE, $urandom);
    repeat (6) cycle(0, 1, 1, 0, '0, $urandom);

    for (int i = 0; i < 3000; i++) begin
      bit rst, ack, rdy, rv;
      logic [31:0] rpc;
      rst = ($urandom_range(99) == 0);
      ack = ($urandom_range(9) < 6);
      rdy = ($urandom_range(9) < 6);
      rv  = !rst && ($urandom_range(19) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3))) : $urandom;
      cycle(rst, ack, rdy, rv, rpc, $urandom);
    end

    check("wrap_seen", 32'(w_seen), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
